glitch_pulse_seq: RTL and testbench
===================================

GLITCH_PULSE_SEQ -- requirements
Module: glitch_pulse_seq

Interface
REQ-001 SHALL have parameter: CNT_W, 16, width of delay/width/gap counters and config data bus.
REQ-002 SHALL have parameter: NUM_PULSES, 4, maximum pulses per triggered train (power of two, 1..16).
REQ-003 SHALL have one clock; reset is asynchronous and active-high. Ports are named clk and rst.
REQ-004 SHALL have port: clk  input  1  clock.
REQ-005 SHALL have port: rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port: cfg_we_i  input  1  config register write strobe.
REQ-007 SHALL have port: cfg_addr_i  input  3  register select (0 delay, 1 width, 2 gap, 3 count, 4 mode).
REQ-008 SHALL have port: cfg_data_i  input  CNT_W  config write data.
REQ-009 SHALL have port: arm_i  input  1  arm request, single-cycle pulse.
REQ-010 SHALL have port: abort_i  input  1  cancel any run.
REQ-011 SHALL have port: trigger_i  input  1  external trigger from target.
REQ-012 SHALL have port: pulse_o  output  1  registered glitch pulse.
REQ-013 SHALL have port: armed_o  output  1  high while waiting for trigger.
REQ-014 SHALL have port: busy_o  output  1  high in any state except IDLE.
REQ-015 SHALL have port: done_o  output  1  one-cycle pulse when a train completes.
REQ-016 SHALL have port: pulse_cnt_o  output  5  pulses issued in current/last train.

Function
REQ-017 SHALL implement states IDLE, ARMED, DELAY, PULSE, GAP.
REQ-018 SHALL accept cfg writes only in IDLE; writes while busy_o=1 are ignored; unused addresses 5..7 are ignored.
REQ-019 SHALL treat width=0 as 1, gap=0 as 1, count=0 as 1, and clamp count above NUM_PULSES to NUM_PULSES.
REQ-020 SHALL use mode bit0 for edge select (0 rising, 1 falling); other mode bits are ignored.
REQ-021 IDLE: arm_i moves to ARMED next cycle; pulse_cnt_o clears to 0 on that transition.
REQ-022 SHALL detect the edge by comparing trigger sample with the previous sample, only while in ARMED; an edge coincident with arm_i is not seen.
REQ-023 With the edge detected at cycle T, pulse_o SHALL rise at cycle T+1+delay and stay high for exactly width cycles; delay=0 enters PULSE directly.
REQ-024 SHALL increment pulse_cnt_o in the cycle pulse_o rises.
REQ-025 After each pulse, if pulses issued < count, SHALL hold pulse_o low for exactly gap cycles then pulse again.
REQ-026 After the last pulse, SHALL go to IDLE and assert done_o for one cycle on the first cycle pulse_o is low.
REQ-027 abort_i in any state SHALL force IDLE and pulse_o=0 on the next cycle, with no done_o; abort_i wins over a simultaneous arm_i.
REQ-028 SHALL ignore arm_i when not in IDLE and ignore trigger edges outside ARMED (no re-trigger mid-train).
REQ-029 armed_o and busy_o SHALL be registered and consistent with the state.

Reset
REQ-030 rst SHALL force state IDLE, pulse_o=0, armed_o=0, busy_o=0, done_o=0, and pulse_cnt_o=0 immediately.
REQ-031 rst SHALL force config registers to delay=0, width=1, gap=1, count=1, mode=0, and clear the edge-detect history.
REQ-032 rst asserted mid-pulse SHALL drop pulse_o asynchronously; after release, the block waits in IDLE for a new arm_i.

Configuration
REQ-033 The macro GLITCH_TRIG_SYNC_EN SHALL control trigger synchronisation:
- Defined: trigger_i passes through a two-flop synchroniser before edge detection, adding exactly 2 cycles to REQ-023 latency (pulse at T+3+delay relative to the raw input edge cycle T).
- Undefined: trigger_i is sampled directly, and REQ-023 timing holds as written.

Verification
REQ-034 Default config, arm, rising edge at cycle T -> pulse_o high only in cycle T+1, done_o at T+2, pulse_cnt_o=1.
REQ-035 delay=10, width=3, gap=4, count=3, rising edge at T -> pulses at T+11..T+13, T+18..T+20, T+25..T+27; done_o at T+28; pulse_cnt_o=3.
REQ-036 mode=1, count=9 (NUM_PULSES=4), falling edge -> exactly 4 pulses, pulse_cnt_o=4; rising edges are ignored.
REQ-037 abort_i during the second pulse of a count=3 train -> pulse_o low next cycle, IDLE, no done_o, and a further trigger edge produces no pulse.
REQ-038 cfg write delay=50 while busy -> ignored; the next run uses the old delay; arm+abort in the same cycle -> stays IDLE.
REQ-039 With GLITCH_TRIG_SYNC_EN defined, delay=0 and raw edge at T -> pulse_o high at T+3.

Source files
------------

// File: rtl/glitch_pulse_seq.sv
// Glitch pulse sequencer: arm, wait for a trigger edge, then emit a train of
// delayed pulses. Define GLITCH_TRIG_SYNC_EN to add a two-flop trigger synchroniser.
module glitch_pulse_seq #(
  parameter int CNT_W      = 16,
  parameter int NUM_PULSES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we_i,
  input  logic [2:0]       cfg_addr_i,
  input  logic [CNT_W-1:0] cfg_data_i,
  input  logic             arm_i,
  input  logic             abort_i,
  input  logic             trigger_i,
  output logic             pulse_o,
  output logic             armed_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [4:0]       pulse_cnt_o
);

  // state   | meaning
  // S_IDLE  | waiting for arm_i; config writable
  // S_ARMED | waiting for the selected trigger edge
  // S_DELAY | counting down the trigger-to-first-pulse delay
  // S_PULSE | pulse_o high, counting down the width
  // S_GAP   | pulse_o low between pulses, counting down the gap
  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_DELAY, S_PULSE, S_GAP} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [4:0]       pcnt_nxt;
  logic             done_nxt;

  logic [CNT_W-1:0] cfg_delay, cfg_width, cfg_gap, cfg_count;
  logic             cfg_fall;
  logic [CNT_W-1:0] width_eff, gap_eff;
  logic [4:0]       count_eff;

  logic trig_s, trig_prev, trig_edge;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_delay <= '0;
      cfg_width <= CNT_W'(1);
      cfg_gap   <= CNT_W'(1);
      cfg_count <= CNT_W'(1);
      cfg_fall  <= 1'b0;
    end else if (cfg_we_i && state == S_IDLE) begin
      case (cfg_addr_i)
        3'd0: cfg_delay <= cfg_data_i;
        3'd1: cfg_width <= cfg_data_i;
        3'd2: cfg_gap   <= cfg_data_i;
        3'd3: cfg_count <= cfg_data_i;
        3'd4: cfg_fall  <= cfg_data_i[0];
        default: ;
      endcase
    end
  end

  assign width_eff = (cfg_width == '0) ? CNT_W'(1) : cfg_width;
  assign gap_eff   = (cfg_gap == '0) ? CNT_W'(1) : cfg_gap;
  assign count_eff = (cfg_count == '0) ? 5'd1 :
                     (cfg_count >= CNT_W'(NUM_PULSES)) ? 5'(NUM_PULSES) : cfg_count[4:0];

`ifdef GLITCH_TRIG_SYNC_EN
  logic [1:0] trig_sync;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) trig_sync <= 2'b00;
    else     trig_sync <= {trig_sync[0], trigger_i};
  end
  assign trig_s = trig_sync[1];
`else
  assign trig_s = trigger_i;
`endif

  // History updates every cycle, so an edge coincident with arm_i is already stale in ARMED.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) trig_prev <= 1'b0;
    else     trig_prev <= trig_s;
  end

  assign trig_edge = cfg_fall ? (trig_prev & ~trig_s) : (~trig_prev & trig_s);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pcnt_nxt  = pulse_cnt_o;
    done_nxt  = 1'b0;
    if (abort_i) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (arm_i) begin
            state_nxt = S_ARMED;
            pcnt_nxt  = 5'd0;
          end
        end
        S_ARMED: begin
          if (trig_edge) begin
            if (cfg_delay == '0) begin
              state_nxt = S_PULSE;
              cnt_nxt   = width_eff - CNT_W'(1);
              pcnt_nxt  = pulse_cnt_o + 5'd1;
            end else begin
              state_nxt = S_DELAY;
              cnt_nxt   = cfg_delay - CNT_W'(1);
            end
          end
        end
        S_DELAY, S_GAP: begin
          if (cnt == '0) begin
            state_nxt = S_PULSE;
            cnt_nxt   = width_eff - CNT_W'(1);
            pcnt_nxt  = pulse_cnt_o + 5'd1;
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
        S_PULSE: begin
          if (cnt == '0) begin
            if (pulse_cnt_o < count_eff) begin
              state_nxt = S_GAP;
              cnt_nxt   = gap_eff - CNT_W'(1);
            end else begin
              state_nxt = S_IDLE;
              done_nxt  = 1'b1;
            end
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      pulse_cnt_o <= 5'd0;
      pulse_o     <= 1'b0;
      armed_o     <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      pulse_cnt_o <= pcnt_nxt;
      pulse_o     <= (state_nxt == S_PULSE);
      armed_o     <= (state_nxt == S_ARMED);
      busy_o      <= (state_nxt != S_IDLE);
      done_o      <= done_nxt;
    end
  end

endmodule

// File: tb/tb_glitch_pulse_seq.sv
// Bench for glitch_pulse_seq: directed and randomized pulse trains against an
// arithmetic model of the pulse schedule; honours GLITCH_TRIG_SYNC_EN latency.
module tb_glitch_pulse_seq;
  localparam int CNT_W      = 16;
  localparam int NUM_PULSES = 4;
`ifdef GLITCH_TRIG_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_we_i = 1'b0;
  logic [2:0]       cfg_addr_i = '0;
  logic [CNT_W-1:0] cfg_data_i = '0;
  logic             arm_i = 1'b0;
  logic             abort_i = 1'b0;
  logic             trigger_i = 1'b0;
  logic             pulse_o, armed_o, busy_o, done_o;
  logic [4:0]       pulse_cnt_o;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  glitch_pulse_seq #(.CNT_W(CNT_W), .NUM_PULSES(NUM_PULSES)) dut (
    .clk(clk), .rst(rst), .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i),
    .cfg_data_i(cfg_data_i), .arm_i(arm_i), .abort_i(abort_i), .trigger_i(trigger_i),
    .pulse_o(pulse_o), .armed_o(armed_o), .busy_o(busy_o), .done_o(done_o),
    .pulse_cnt_o(pulse_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic cfg_write(input logic [2:0] a, input int d);
    cfg_we_i   = 1'b1;
    cfg_addr_i = a;
    cfg_data_i = CNT_W'(d);
    tick();
    cfg_we_i = 1'b0;
  endtask

  // Writes all registers, then a junk write to an unused address that must not disturb them.
  task automatic set_cfg(input int d, input int w, input int g, input int c, input bit fall);
    cfg_write(3'd0, d);
    cfg_write(3'd1, w);
    cfg_write(3'd2, g);
    cfg_write(3'd3, c);
    cfg_write(3'd4, {$urandom_range(0, 32767), fall});
    cfg_write(3'($urandom_range(5, 7)), int'($urandom_range(0, 65535)));
  endtask

  // Arms, presents a wrong-polarity edge (must be ignored), then the wanted edge at cycle t.
  task automatic arm_and_edge(input bit fall, input string name, output int t);
    trigger_i = ~fall;
    repeat (4) tick();
    arm_i = 1'b1;
    tick();
    arm_i = 1'b0;
    repeat (2) tick();
    trigger_i = fall;
    repeat (3) tick();
    trigger_i = ~fall;
    t = cyc;
    checks++;
    if (armed_o !== 1'b1 || busy_o !== 1'b1 || pulse_cnt_o !== 5'd0) begin
      failures++;
      $display("FAIL %s armed_state got armed=%b busy=%b cnt=%0d want armed=1 busy=1 cnt=0",
               name, armed_o, busy_o, pulse_cnt_o);
    end
  endtask

  task automatic run_train(input int d, input int w, input int g, input int c, input bit fall,
                           input bit write_cfg, input bit busy_write, input string name);
    int weff, geff, n, t, first, done_c, exp_cnt, s;
    bit exp_p, exp_done, exp_busy;
    int perr, derr, cerr, berr, bad_p, bad_d, bad_c, bad_b;
    weff = (w == 0) ? 1 : w;
    geff = (g == 0) ? 1 : g;
    n = (c == 0) ? 1 : ((c > NUM_PULSES) ? NUM_PULSES : c);
    if (write_cfg) set_cfg(d, w, g, c, fall);
    arm_and_edge(fall, name, t);
    first  = t + LAT + d;
    done_c = first + n * weff + (n - 1) * geff;
    perr = 0; derr = 0; cerr = 0; berr = 0;
    bad_p = -1; bad_d = -1; bad_c = -1; bad_b = -1;
    while (cyc < done_c + 3) begin
      if (cyc == t + 1) trigger_i = fall;
      if (cyc == t + 5) trigger_i = ~fall;
      if (busy_write && cyc == t + 1) begin
        cfg_we_i = 1'b1; cfg_addr_i = 3'd0; cfg_data_i = CNT_W'(50);
      end else begin
        cfg_we_i = 1'b0;
      end
      tick();
      exp_p = 1'b0;
      exp_cnt = 0;
      for (int k = 0; k < n; k++) begin
        s = first + k * (weff + geff);
        if (cyc >= s && cyc < s + weff) exp_p = 1'b1;
        if (cyc >= s) exp_cnt++;
      end
      exp_done = (cyc == done_c);
      exp_busy = (cyc < done_c);
      if (pulse_o !== exp_p) begin perr++; if (bad_p < 0) bad_p = cyc - t; end
      if (done_o !== exp_done) begin derr++; if (bad_d < 0) bad_d = cyc - t; end
      if (pulse_cnt_o !== 5'(exp_cnt)) begin cerr++; if (bad_c < 0) bad_c = cyc - t; end
      if (busy_o !== exp_busy) begin berr++; if (bad_b < 0) bad_b = cyc - t; end
    end
    cfg_we_i = 1'b0;
    checks++;
    if (perr != 0) begin
      failures++;
      $display("FAIL %s pulse_wave got %0d bad cycles (first at T+%0d) want 0 (d=%0d w=%0d g=%0d c=%0d)",
               name, perr, bad_p, d, w, g, c);
    end
    checks++;
    if (derr != 0) begin
      failures++;
      $display("FAIL %s done_wave got %0d bad cycles (first at T+%0d) want 0", name, derr, bad_d);
    end
    checks++;
    if (cerr != 0) begin
      failures++;
      $display("FAIL %s pulse_cnt_track got %0d bad cycles (first at T+%0d) want 0", name, cerr, bad_c);
    end
    checks++;
    if (berr != 0) begin
      failures++;
      $display("FAIL %s busy_wave got %0d bad cycles (first at T+%0d) want 0", name, berr, bad_b);
    end
    checks++;
    if (pulse_cnt_o !== 5'(n)) begin
      failures++;
      $display("FAIL %s final_pulse_cnt got %0d want %0d", name, pulse_cnt_o, n);
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++;
    if ({pulse_o, armed_o, busy_o, done_o, pulse_cnt_o} !== 9'd0) begin
      failures++;
      $display("FAIL reset_hold got p=%b a=%b b=%b d=%b cnt=%0d want all 0",
               pulse_o, armed_o, busy_o, done_o, pulse_cnt_o);
    end
    rst = 1'b0;
    repeat (2) tick();
    checks++;
    if ({pulse_o, armed_o, busy_o, done_o, pulse_cnt_o} !== 9'd0) begin
      failures++;
      $display("FAIL reset_release got p=%b a=%b b=%b d=%b cnt=%0d want all 0",
               pulse_o, armed_o, busy_o, done_o, pulse_cnt_o);
    end
  endtask

  task automatic test_default_train();
    run_train(0, 1, 1, 1, 1'b0, 1'b0, 1'b0, "default_cfg");
  endtask

  task automatic test_spec_example();
    run_train(10, 3, 4, 3, 1'b0, 1'b1, 1'b0, "delay10_w3_g4_c3");
    run_train(0, 0, 0, 0, 1'b0, 1'b1, 1'b0, "zero_fields");
  endtask

  task automatic test_clamp_falling();
    run_train(3, 2, 2, 9, 1'b1, 1'b1, 1'b0, "falling_clamp9");
  endtask

  task automatic test_busy_write();
    run_train(5, 2, 1, 1, 1'b0, 1'b1, 1'b1, "busy_write");
    run_train(5, 2, 1, 1, 1'b0, 1'b0, 1'b0, "after_busy_write");
  endtask

  task automatic test_arm_abort();
    arm_i = 1'b1;
    abort_i = 1'b1;
    tick();
    arm_i = 1'b0;
    abort_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || armed_o !== 1'b0) begin
      failures++;
      $display("FAIL arm_abort_same_cycle got busy=%b armed=%b want 0 0", busy_o, armed_o);
    end
    tick();
    checks++;
    if (busy_o !== 1'b0) begin
      failures++;
      $display("FAIL arm_abort_stays_idle got busy=%b want 0", busy_o);
    end
  endtask

  task automatic test_abort();
    int t, s2, seen_p, seen_d, seen_b;
    set_cfg(2, 4, 2, 3, 1'b0);
    arm_and_edge(1'b0, "abort", t);
    s2 = t + LAT + 2 + 4 + 2;
    while (cyc < s2 + 1) tick();
    checks++;
    if (pulse_o !== 1'b1 || pulse_cnt_o !== 5'd2) begin
      failures++;
      $display("FAIL abort_second_pulse got p=%b cnt=%0d want p=1 cnt=2", pulse_o, pulse_cnt_o);
    end
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    checks++;
    if (pulse_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      failures++;
      $display("FAIL abort_next_cycle got p=%b busy=%b done=%b want 0 0 0", pulse_o, busy_o, done_o);
    end
    seen_p = 0; seen_d = 0; seen_b = 0;
    for (int k = 0; k < 24; k++) begin
      if (k == 3) trigger_i = 1'b0;
      if (k == 6) trigger_i = 1'b1;
      tick();
      if (pulse_o === 1'b1) seen_p++;
      if (done_o === 1'b1) seen_d++;
      if (busy_o === 1'b1) seen_b++;
    end
    checks++;
    if (seen_p + seen_d + seen_b != 0) begin
      failures++;
      $display("FAIL abort_quiet got pulses=%0d dones=%0d busy=%0d cycles want 0", seen_p, seen_d, seen_b);
    end
  endtask

  task automatic test_reset_mid();
    int t, seen;
    set_cfg(3, 6, 1, 2, 1'b0);
    arm_and_edge(1'b0, "reset_mid", t);
    while (cyc < t + LAT + 3 + 2) tick();
    checks++;
    if (pulse_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_pre got p=%b want 1", pulse_o);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({pulse_o, armed_o, busy_o, done_o, pulse_cnt_o} !== 9'd0) begin
      failures++;
      $display("FAIL reset_mid_async got p=%b a=%b b=%b d=%b cnt=%0d want all 0",
               pulse_o, armed_o, busy_o, done_o, pulse_cnt_o);
    end
    #2;
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      trigger_i = k[1];
      tick();
      if (pulse_o === 1'b1 || busy_o === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL reset_mid_idle got %0d active cycles want 0", seen);
    end
    run_train(0, 1, 1, 1, 1'b0, 1'b0, 1'b0, "post_reset_defaults");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      run_train(int'($urandom_range(0, 20)), int'($urandom_range(0, 4)),
                int'($urandom_range(0, 4)), int'($urandom_range(0, 9)),
                1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_default_train();
    test_spec_example();
    test_clamp_falling();
    test_busy_write();
    test_arm_abort();
    test_abort();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
